div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_div_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Shared pipeline package: divider FSM state encoding, the default operand
// width for the divider, and the operand forward-select encodings used by the
// hazard unit and the E-stage operand muxes.
// ---------------------------------------------------------------------------
package div_unit_pkg;

    // Default operand/result width of the iterative divider.
    localparam int DIV_W_DEFAULT = 32;

    // Iterative divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Operand forward-select encodings (E-stage operand mux control).
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring divider for the E stage (DIV / DIVU).
// One quotient bit per cycle, MSB first, on operand magnitudes; signs are
// applied when the last bit is produced so the results are registered.
//
// Ports:
//   clk              rising-edge clock
//   resetn           asynchronous active-low reset
//   div_startE       divide instruction present in E (held while E stalls)
//   div_signedE      1 = signed DIV, 0 = DIVU
//   src_aE / src_bE  dividend / divisor
//   ext_stallE       E held by something other than this block
//   flush_exceptionM abort any operation in progress
//   div_stallE       stall request to the hazard unit (combinational)
//   div_validE       results valid this cycle
//   div_quoE         quotient (to LO)
//   div_remE         remainder (to HI)
// ---------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic [DIV_W-1:0] src_aE,
    input  logic [DIV_W-1:0] src_bE,
    input  logic             ext_stallE,
    input  logic             flush_exceptionM,
    output logic             div_stallE,
    output logic             div_validE,
    output logic [DIV_W-1:0] div_quoE,
    output logic [DIV_W-1:0] div_remE
);

    localparam int               CNT_W    = $clog2(DIV_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits, and shift the resulting
    // quotient bit into the low end of the dividend/quotient register.
    // Returns {next_remainder, next_quotient}.
    function automatic logic [2*DIV_W-1:0] div_step(
        input logic [DIV_W-1:0] rem,
        input logic [DIV_W-1:0] quo,
        input logic [DIV_W-1:0] dvs
    );
        logic [DIV_W:0]   trial;
        logic [DIV_W:0]   diff;
        logic [DIV_W-1:0] rem_n;
        logic [DIV_W-1:0] quo_n;
        trial = {rem, quo[DIV_W-1]};
        diff  = trial - {1'b0, dvs};
        // A clear borrow bit means the divisor fitted into the trial value.
        if (diff[DIV_W] == 1'b0) begin
            rem_n = diff[DIV_W-1:0];
            quo_n = {quo[DIV_W-2:0], 1'b1};
        end else begin
            rem_n = {rem[DIV_W-2:0], quo[DIV_W-1]};
            quo_n = {quo[DIV_W-2:0], 1'b0};
        end
        return {rem_n, quo_n};
    endfunction

    // Two's-complement negate when the sign flag is set.
    function automatic logic [DIV_W-1:0] apply_sign(
        input logic [DIV_W-1:0] mag,
        input logic             neg
    );
        logic [DIV_W-1:0] res;
        if (neg) begin
            res = (~mag) + ONE;
        end else begin
            res = mag;
        end
        return res;
    endfunction

    div_state_e       state_r;
    logic [CNT_W-1:0] count_r;
    logic [DIV_W-1:0] rem_r;       // partial remainder
    logic [DIV_W-1:0] quo_r;       // dividend bits shifting out, quotient bits in
    logic [DIV_W-1:0] dvs_r;       // divisor magnitude
    logic [DIV_W-1:0] a_raw_r;     // dividend as issued, for divide-by-zero
    logic             qsign_r;
    logic             rsign_r;
    logic             bzero_r;
    logic [DIV_W-1:0] res_quo_r;
    logic [DIV_W-1:0] res_rem_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [DIV_W-1:0] a_abs_s;
    logic [DIV_W-1:0] b_abs_s;
    logic [2*DIV_W-1:0] step_s;
    logic [DIV_W-1:0] step_rem_s;
    logic [DIV_W-1:0] step_quo_s;
    logic [DIV_W-1:0] fin_quo_s;
    logic [DIV_W-1:0] fin_rem_s;

    // Operand magnitudes and sign capture for the start cycle.
    always_comb begin
        a_neg_s = div_signedE & src_aE[DIV_W-1];
        b_neg_s = div_signedE & src_bE[DIV_W-1];
        a_abs_s = apply_sign(src_aE, a_neg_s);
        b_abs_s = apply_sign(src_bE, b_neg_s);
    end

    // Current iteration step and the sign-corrected final results.
    always_comb begin
        step_s     = div_step(rem_r, quo_r, dvs_r);
        step_rem_s = step_s[2*DIV_W-1:DIV_W];
        step_quo_s = step_s[DIV_W-1:0];
        // Divide-by-zero yields all-ones and the untouched dividend for both
        // DIV and DIVU, so the sign correction is bypassed.
        if (bzero_r) begin
            fin_quo_s = '1;
            fin_rem_s = a_raw_r;
        end else begin
            fin_quo_s = apply_sign(step_quo_s, qsign_r);
            fin_rem_s = apply_sign(step_rem_s, rsign_r);
        end
    end

    // Stall request: held through the start cycle and every BUSY step, never
    // in DONE, in a flush cycle, or while reset is asserted.
    always_comb begin
        div_stallE = resetn & div_startE & (state_r != DONE) & ~flush_exceptionM;
    end

    // Control FSM and iteration datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            count_r   <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            a_raw_r   <= '0;
            qsign_r   <= 1'b0;
            rsign_r   <= 1'b0;
            bzero_r   <= 1'b0;
            res_quo_r <= '0;
            res_rem_r <= '0;
        end else if (flush_exceptionM) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (div_startE) begin
                        rem_r   <= '0;
                        quo_r   <= a_abs_s;
                        dvs_r   <= b_abs_s;
                        a_raw_r <= src_aE;
                        qsign_r <= a_neg_s ^ b_neg_s;
                        rsign_r <= a_neg_s;
                        bzero_r <= (src_bE == '0);
                        count_r <= '0;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // Start dropping mid-operation means the instruction was
                    // squashed upstream; abandon the operation.
                    if (!div_startE) begin
                        state_r <= IDLE;
                    end else begin
                        rem_r   <= step_rem_s;
                        quo_r   <= step_quo_s;
                        count_r <= count_r + CNT_ONE;
                        if (count_r == CNT_LAST) begin
                            res_quo_r <= fin_quo_s;
                            res_rem_r <= fin_rem_s;
                            state_r   <= DONE;
                        end else begin
                            state_r   <= BUSY;
                        end
                    end
                end
                DONE: begin
                    // Hold the result while E is frozen by something else so
                    // the same instruction does not restart.
                    if (ext_stallE) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign div_validE = (state_r == DONE);
    assign div_quoE   = res_quo_r;
    assign div_remE   = res_rem_r;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Directed self-checking bench for div_unit with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        div_startE;
    logic        div_signedE;
    logic [31:0] src_aE;
    logic [31:0] src_bE;
    logic        ext_stallE;
    logic        flush_exceptionM;
    logic        div_stallE;
    logic        div_validE;
    logic [31:0] div_quoE;
    logic [31:0] div_remE;

    int vectors;
    int miscompares;

    div_unit #(.DIV_W(32)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .div_startE       (div_startE),
        .div_signedE      (div_signedE),
        .src_aE           (src_aE),
        .src_bE           (src_bE),
        .ext_stallE       (ext_stallE),
        .flush_exceptionM (flush_exceptionM),
        .div_stallE       (div_stallE),
        .div_validE       (div_validE),
        .div_quoE         (div_quoE),
        .div_remE         (div_remE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one divide starting now (posedge+2), count stall cycles, check
    // the result, optionally hold it with ext_stallE, and return at posedge+2
    // of the cycle after DONE with div_startE still high.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input int hold);
        int cnt;
        logic saw_valid;
        cnt = 0;
        saw_valid = 1'b0;
        div_startE  = 1'b1;
        div_signedE = sgn;
        src_aE      = a;
        src_bE      = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_stallE !== 1'b1) break;
            if (div_validE === 1'b1) saw_valid = 1'b1;
            cnt++;
        end
        check({tag, " stall_cycles"}, 32'(cnt), 32'd33);
        check({tag, " valid_in_stall"}, {31'd0, saw_valid}, 32'd0);
        check({tag, " valid"}, {31'd0, div_validE}, 32'd1);
        check({tag, " quo"}, div_quoE, exp_q);
        check({tag, " rem"}, div_remE, exp_r);
        for (int i = 0; i < hold; i++) begin
            ext_stallE = 1'b1;
            @(posedge clk); #2;
            @(negedge clk);
            check({tag, " hold_valid"}, {31'd0, div_validE}, 32'd1);
            check({tag, " hold_stall"}, {31'd0, div_stallE}, 32'd0);
            check({tag, " hold_quo"}, div_quoE, exp_q);
            check({tag, " hold_rem"}, div_remE, exp_r);
        end
        ext_stallE = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic go_idle();
        div_startE = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        resetn           = 1'b0;
        div_startE       = 1'b1;
        div_signedE      = 1'b0;
        src_aE           = 32'd0;
        src_bE           = 32'd0;
        ext_stallE       = 1'b0;
        flush_exceptionM = 1'b0;

        // Reset state, with a start pending to show stall is gated.
        repeat (2) @(posedge clk);
        #2;
        check("rst stall", {31'd0, div_stallE}, 32'd0);
        check("rst valid", {31'd0, div_validE}, 32'd0);
        check("rst quo", div_quoE, 32'd0);
        check("rst rem", div_remE, 32'd0);
        div_startE = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #2;

        // Main arithmetic cases.
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        go_idle();
        check("idle_after_done valid", {31'd0, div_validE}, 32'd0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        go_idle();
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
        go_idle();
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 0);
        go_idle();
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        go_idle();
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 0);
        go_idle();
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
        go_idle();
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);
        go_idle();

        // Flush at BUSY step 10, then an immediate new start.
        div_startE  = 1'b1;
        div_signedE = 1'b0;
        src_aE      = 32'd1000;
        src_bE      = 32'd3;
        repeat (11) begin
            @(posedge clk); #2;
        end
        flush_exceptionM = 1'b1;
        @(negedge clk);
        check("flush stall", {31'd0, div_stallE}, 32'd0);
        check("flush valid", {31'd0, div_validE}, 32'd0);
        @(posedge clk); #2;
        flush_exceptionM = 1'b0;
        check("post_flush valid", {31'd0, div_validE}, 32'd0);
        run_div("after_flush_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
        go_idle();

        // Result held under ext_stallE, then back-to-back divides.
        run_div("hold_45_4", 1'b0, 32'd45, 32'd4, 32'd11, 32'd1, 4);
        run_div("b2b_1", 1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 0);
        run_div("b2b_2", 1'b1, 32'hFFFF_FFCE, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        go_idle();

        // Start dropping while BUSY abandons the operation.
        div_startE = 1'b1;
        src_aE     = 32'd50;
        src_bE     = 32'd5;
        repeat (6) begin
            @(posedge clk); #2;
        end
        div_startE = 1'b0;
        repeat (40) begin
            @(posedge clk); #2;
        end
        check("squash valid", {31'd0, div_validE}, 32'd0);

        // Reset mid-BUSY, then a fresh operation.
        div_startE = 1'b1;
        src_aE     = 32'd1234;
        src_bE     = 32'd7;
        repeat (6) begin
            @(posedge clk); #2;
        end
        resetn = 1'b0;
        #1;
        check("midrst stall", {31'd0, div_stallE}, 32'd0);
        check("midrst valid", {31'd0, div_validE}, 32'd0);
        check("midrst quo", div_quoE, 32'd0);
        check("midrst rem", div_remE, 32'd0);
        @(posedge clk); #2;
        resetn = 1'b1;
        run_div("after_rst_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 0);
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
